risc_v_operand_stage: RTL
=========================

Name: risc_v_operand_stage

Overview:
- Decode/operand stage directly upstream of risc_v_alu.
- Accepts fetched instructions with pc over a valid/ready handshake and reads the 32x32 register file. Write-back is bypassed into the read path.
- Builds operand1/operand2 per instruction format and tracks pending writes with a per-register scoreboard that stalls RAW/WAW hazards.
- Drives a registered instr/operands/pc bundle plus enable to the ALU.

Parameters:
- XLEN, 32, datapath width.
- NREGS, 32, architectural registers; x0 is hardwired to zero.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  synchronous active-low reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_instr  in  32  instruction_t.
- in_pc  in  32  instruction address.
- ex_enable  out  1  output bundle valid; drives ALU enable.
- ex_ready  in  1  downstream consumes bundle this cycle.
- ex_instr  out  32  registered instruction.
- ex_operand1  out  32  registered operand1.
- ex_operand2  out  32  registered operand2.
- ex_pc  out  32  registered pc.
- ex_rd  out  5  destination register (0 if none).
- flush  in  1  kill held bundle.
- wb_we  in  1  write-back strobe.
- wb_rd  in  5  write-back register.
- wb_data  in  32  write-back value.
- illegal  out  1  one-cycle pulse when an unsupported instruction is accepted.

Behaviour:
- Reset (reset_n=0 at posedge):
  - ex_enable=0; ex_instr/operands/pc/rd=0; illegal=0.
  - All registers and scoreboard bits cleared.
  - in_ready=0 while reset_n=0.
- Field extraction: rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7].
- Register read:
  - x0 reads 0.
  - If wb_we && wb_rd==rsN && rsN!=0 in the same cycle, wb_data is returned (write-before-read bypass).
- Operand formation:
  - R-type ALU ops: op1=rs1, op2=rs2.
  - I-type ALU ops (ADDI/ANDI/ORI/XORI/SLTI/SLTIU): op1=rs1, op2=sign-extended instr[31:20].
  - SLLI/SRLI/SRAI: op2={27'b0, instr[24:20]}.
  - LUI and AUIPC: op1={instr[31:12],12'b0}, op2=0.
- Uses flags: rs1 for R/I; rs2 for R only; neither for LUI/AUIPC.
- Scoreboard: pending[31:1], one bit per register.
  - Set on issue of an instruction with rd!=0.
  - Cleared on wb_we with wb_rd!=0.
  - Same-cycle set and clear of the same register: set wins.
  - pending[0] is always 0.
- Stall: hazard = (uses rs1 && pending[rs1] && !clear_now(rs1)) || (uses rs2 && pending[rs2] && !clear_now(rs2)) || (rd!=0 && pending[rd] && !clear_now(rd)).
- in_ready = reset_n && !hazard && (!ex_enable || ex_ready) && !flush.
- Issue (in_valid && in_ready): on the next edge the bundle loads, ex_enable=1, and the scoreboard is set.
- Hold: if ex_enable && !ex_ready, the bundle stays unchanged.
- Drain: ex_ready && no issue clears ex_enable.
- Issue and drain in the same cycle: the new bundle replaces the old one (back-to-back throughput of 1/cycle).
- Latency: accept to ex_enable is 1 cycle.
- Flush:
  - Next edge: ex_enable=0.
  - If the held bundle had rd!=0, its pending bit clears, unless wb sets it in the same cycle.
  - No issue occurs during a flush.
- Illegal instruction:
  - Accepted (consumes the handshake), illegal=1 for one cycle, not forwarded (ex_enable stays 0), scoreboard untouched.
- Register-file writes with wb_rd=0 are ignored.
- Mid-operation reset overrides flush, write-back and issue.

Decomposition:
- Add to opcodes package: reg_idx_t (5-bit), operand_fmt_t enum {FMT_R, FMT_I, FMT_SHIFT, FMT_U, FMT_BAD}, and an imm_sext12 function.
- One sub-module: risc_v_regfile.
  - Two async read ports, one sync write port.
  - Internal bypass, x0 handling, synchronous active-low clear.
- Format classification stays as a casez on the M_* patterns inside the top module.

Test Plan:
- Reset, then ADDI x1,x0,5 with ex_ready=1 -> next cycle ex_enable=1, op1=0, op2=5, ex_rd=1; pending[1]=1.
- RAW: issue ADDI x1; hold wb; present ADD x2,x1,x1 -> in_ready=0. Then wb_we=1,x1,5 -> accepted that cycle with op1=op2=5.
- Backpressure: ex_ready=0 with two queued instrs -> bundle held stable across 3 cycles, in_ready=0. Release -> back-to-back ex_enable.
- LUI x3,0xABCDE -> op1=32'hABCDE000, op2=0. SRAI x4,x5,31 with x5=0x80000000 -> op2=31. SLTI imm=-1 -> op2=32'hFFFFFFFF.
- Flush while holding ADDI x6 (ex_ready=0) -> ex_enable=0 next cycle, pending[6]=0, and a following ADD x7,x6,x0 issues without stall.
- wb_rd=0 write of 0xDEADBEEF -> x0 reads 0. Illegal opcode -> illegal pulse, ex_enable stays 0. reset_n low while ex_enable=1 -> all outputs 0 next edge.

Source files
------------

// File: rtl/risc_v_operand_stage_pkg.sv
// rtl/risc_v_operand_stage_pkg.sv - shared types, instruction match patterns and immediate helper
package risc_v_operand_stage_pkg;

  typedef logic [4:0]  reg_idx_t;
  typedef logic [31:0] instruction_t;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_SHIFT,
    FMT_U,
    FMT_BAD
  } operand_fmt_t;

  localparam logic [31:0] M_R_BASE = 32'b0000000_?????_?????_???_?????_0110011;
  localparam logic [31:0] M_SUB    = 32'b0100000_?????_?????_000_?????_0110011;
  localparam logic [31:0] M_SRA    = 32'b0100000_?????_?????_101_?????_0110011;
  localparam logic [31:0] M_ADDI   = 32'b????????????_?????_000_?????_0010011;
  localparam logic [31:0] M_SLTI   = 32'b????????????_?????_010_?????_0010011;
  localparam logic [31:0] M_SLTIU  = 32'b????????????_?????_011_?????_0010011;
  localparam logic [31:0] M_XORI   = 32'b????????????_?????_100_?????_0010011;
  localparam logic [31:0] M_ORI    = 32'b????????????_?????_110_?????_0010011;
  localparam logic [31:0] M_ANDI   = 32'b????????????_?????_111_?????_0010011;
  localparam logic [31:0] M_SLLI   = 32'b0000000_?????_?????_001_?????_0010011;
  localparam logic [31:0] M_SRLI   = 32'b0000000_?????_?????_101_?????_0010011;
  localparam logic [31:0] M_SRAI   = 32'b0100000_?????_?????_101_?????_0010011;
  localparam logic [31:0] M_LUI    = 32'b????????????????????_?????_0110111;
  localparam logic [31:0] M_AUIPC  = 32'b????????????????????_?????_0010111;

  function automatic logic [31:0] imm_sext12(input logic [11:0] imm);
    return {{20{imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/risc_v_regfile.sv
// rtl/risc_v_regfile.sv - 2R1W register file with write-before-read bypass and hardwired x0
module risc_v_regfile
  import risc_v_operand_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  reg_idx_t        raddr1,
  output logic [XLEN-1:0] rdata1,
  input  reg_idx_t        raddr2,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  reg_idx_t        waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (we && waddr != '0) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // A write landing this cycle is visible to a read of the same register.
  always_comb begin
    rdata1 = regs_q[raddr1];
    rdata2 = regs_q[raddr2];
    if (we && waddr == raddr1) rdata1 = wdata;
    if (we && waddr == raddr2) rdata2 = wdata;
    if (raddr1 == '0) rdata1 = '0;
    if (raddr2 == '0) rdata2 = '0;
  end

endmodule

// File: rtl/risc_v_operand_stage.sv
// rtl/risc_v_operand_stage.sv - decode/operand stage with scoreboard stall feeding the ALU
module risc_v_operand_stage
  import risc_v_operand_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  instruction_t    in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            ex_enable,
  input  logic            ex_ready,
  output logic [31:0]     ex_instr,
  output logic [XLEN-1:0] ex_operand1,
  output logic [XLEN-1:0] ex_operand2,
  output logic [XLEN-1:0] ex_pc,
  output reg_idx_t        ex_rd,
  input  logic            flush,
  input  logic            wb_we,
  input  reg_idx_t        wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            illegal
);

  logic [NREGS-1:0] pending_q, pending_d;
  logic             ex_enable_q, ex_enable_d;
  logic [31:0]      ex_instr_q, ex_instr_d;
  logic [XLEN-1:0]  ex_operand1_q, ex_operand1_d;
  logic [XLEN-1:0]  ex_operand2_q, ex_operand2_d;
  logic [XLEN-1:0]  ex_pc_q, ex_pc_d;
  reg_idx_t         ex_rd_q, ex_rd_d;
  logic             illegal_q, illegal_d;

  reg_idx_t         rs1, rs2, rd, dst;
  operand_fmt_t     fmt;
  logic             uses_rs1, uses_rs2, hazard, issue, issue_ok;
  logic [XLEN-1:0]  rdata1, rdata2, op1, op2;

  assign rs1 = in_instr[19:15];
  assign rs2 = in_instr[24:20];
  assign rd  = in_instr[11:7];

  risc_v_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
    .clk     (clk),
    .reset_n (reset_n),
    .raddr1  (rs1),
    .rdata1  (rdata1),
    .raddr2  (rs2),
    .rdata2  (rdata2),
    .we      (wb_we),
    .waddr   (wb_rd),
    .wdata   (wb_data)
  );

  always_comb begin
    fmt = FMT_BAD;
    casez (in_instr)
      M_R_BASE, M_SUB, M_SRA:                         fmt = FMT_R;
      M_ADDI, M_SLTI, M_SLTIU, M_XORI, M_ORI, M_ANDI: fmt = FMT_I;
      M_SLLI, M_SRLI, M_SRAI:                         fmt = FMT_SHIFT;
      M_LUI, M_AUIPC:                                 fmt = FMT_U;
      default:                                        fmt = FMT_BAD;
    endcase
  end

  assign uses_rs1 = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_SHIFT);
  assign uses_rs2 = (fmt == FMT_R);
  assign dst      = (fmt == FMT_BAD) ? '0 : rd;

  // A register retiring through write-back this cycle no longer blocks.
  always_comb begin
    hazard = 1'b0;
    if (uses_rs1 && pending_q[rs1] && !(wb_we && wb_rd == rs1)) hazard = 1'b1;
    if (uses_rs2 && pending_q[rs2] && !(wb_we && wb_rd == rs2)) hazard = 1'b1;
    if (dst != '0 && pending_q[dst] && !(wb_we && wb_rd == dst)) hazard = 1'b1;
  end

  assign in_ready = reset_n && !hazard && (!ex_enable_q || ex_ready) && !flush;
  assign issue    = in_valid && in_ready;
  assign issue_ok = issue && (fmt != FMT_BAD);

  always_comb begin
    op1 = rdata1;
    op2 = rdata2;
    case (fmt)
      FMT_I:     op2 = imm_sext12(in_instr[31:20]);
      FMT_SHIFT: op2 = XLEN'(in_instr[24:20]);
      FMT_U: begin
        op1 = {in_instr[31:12], 12'b0};
        op2 = '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    pending_d     = pending_q;
    ex_enable_d   = ex_enable_q;
    ex_instr_d    = ex_instr_q;
    ex_operand1_d = ex_operand1_q;
    ex_operand2_d = ex_operand2_q;
    ex_pc_d       = ex_pc_q;
    ex_rd_d       = ex_rd_q;
    illegal_d     = issue && (fmt == FMT_BAD);
    if (wb_we && wb_rd != '0) pending_d[wb_rd] = 1'b0;
    if (flush) begin
      ex_enable_d = 1'b0;
      if (ex_enable_q && ex_rd_q != '0) pending_d[ex_rd_q] = 1'b0;
    end else if (issue_ok) begin
      ex_enable_d   = 1'b1;
      ex_instr_d    = in_instr;
      ex_operand1_d = op1;
      ex_operand2_d = op2;
      ex_pc_d       = in_pc;
      ex_rd_d       = dst;
      if (dst != '0) pending_d[dst] = 1'b1;
    end else if (ex_ready) begin
      ex_enable_d = 1'b0;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending_q     <= '0;
      ex_enable_q   <= 1'b0;
      ex_instr_q    <= '0;
      ex_operand1_q <= '0;
      ex_operand2_q <= '0;
      ex_pc_q       <= '0;
      ex_rd_q       <= '0;
      illegal_q     <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      ex_enable_q   <= ex_enable_d;
      ex_instr_q    <= ex_instr_d;
      ex_operand1_q <= ex_operand1_d;
      ex_operand2_q <= ex_operand2_d;
      ex_pc_q       <= ex_pc_d;
      ex_rd_q       <= ex_rd_d;
      illegal_q     <= illegal_d;
    end
  end

  assign ex_enable   = ex_enable_q;
  assign ex_instr    = ex_instr_q;
  assign ex_operand1 = ex_operand1_q;
  assign ex_operand2 = ex_operand2_q;
  assign ex_pc       = ex_pc_q;
  assign ex_rd       = ex_rd_q;
  assign illegal     = illegal_q;

endmodule
